tdm_tx: RTL

Parametrised TDM/I2S serial transmitter, clocked from mclk (clk). Accepts one AXI-Stream of samples tagged by channel id and holds one sample per channel. Serialises NCH slots per frame onto sdo against externally supplied sclk/fsync. Successor to the two-channel I2S transmitter: adds channel count, slot width, underrun/frame-error reporting and a synchronous enable. With NCH=2 and a 50%-duty fsync it serves as a standard I2S transmitter.

---
 rtl/tdm_pkg.sv | 20 ++
 rtl/tdm_slot_timer.sv | 107 ++++++++++
 rtl/tdm_tx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and helpers for the TDM/I2S transmitter.
//   state_e    : slot timer state (IDLE, RUN)
//   sample_t   : sample word at the default sample width
//   bcnt_width : counter width for a counter spanning 0..n-1 (never below 1)
package tdm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_DW = 24;

    typedef logic [DEFAULT_DW-1:0] sample_t;

    function automatic int bcnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_timer.sv
// tdm_slot_timer: frame and slot timing for tdm_tx.
// Detects sclk edges and the fsync rising edge (both already synchronous to
// clk), runs the IDLE/RUN state with the bit and channel counters, and reports
// a frame sync that arrives before the current frame has finished.
// Ports:
//   clk, rst      : master clock, synchronous active-high reset
//   en            : when low, a frame start is ignored
//   sclk, fsync   : bit clock and frame sync
//   load, load_ch : strobe to load the shift register from channel load_ch
//   fall          : sclk falling-edge strobe (shift strobe)
//   running       : high while a frame is being transmitted
//   frame_err     : one-clk pulse on an early frame sync
module tdm_slot_timer
    import tdm_pkg::*;
#(
    parameter int SLOT_W = 32,
    parameter int NCH    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         sclk,
    input  logic                         fsync,
    output logic                         load,
    output logic [bcnt_width(NCH)-1:0]   load_ch,
    output logic                         fall,
    output logic                         running,
    output logic                         frame_err
);

    localparam int BW = bcnt_width(SLOT_W);
    localparam int CW = bcnt_width(NCH);
    localparam logic [BW-1:0] LAST_BIT = BW'(SLOT_W - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [CW-1:0] ccnt_q, ccnt_d;
    logic          sclk_q;
    logic          fs_q, fs_d;
    logic          frame_err_q, frame_err_d;
    logic          rise;
    logic          frame_start;

    assign rise        = sclk & ~sclk_q;
    assign fall        = ~sclk & sclk_q;
    // fsync is only meaningful at sclk rising edges, so its history is too.
    assign fs_d        = rise ? fsync : fs_q;
    assign frame_start = rise & fsync & ~fs_q & en;
    assign running     = (state_q == RUN);
    assign frame_err   = frame_err_q;

    // State, counters and edge-detect history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            ccnt_q      <= '0;
            sclk_q      <= 1'b0;
            fs_q        <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            ccnt_q      <= ccnt_d;
            sclk_q      <= sclk;
            fs_q        <= fs_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next state: a frame start always wins and restarts at slot 0; otherwise
    // each rise advances the bit counter, rolling into the next slot, and the
    // frame ends after the last bit of the last slot.
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        ccnt_d      = ccnt_q;
        load        = 1'b0;
        load_ch     = '0;
        frame_err_d = 1'b0;
        if (frame_start) begin
            if (state_q == RUN && !(ccnt_q == LAST_CH && bcnt_q == LAST_BIT)) begin
                frame_err_d = 1'b1;
            end
            bcnt_d  = '0;
            ccnt_d  = '0;
            load    = 1'b1;
            load_ch = '0;
            state_d = RUN;
        end else if (rise && state_q == RUN) begin
            if (bcnt_q != LAST_BIT) begin
                bcnt_d = bcnt_q + 1'b1;
            end else if (ccnt_q != LAST_CH) begin
                bcnt_d  = '0;
                ccnt_d  = ccnt_q + 1'b1;
                load    = 1'b1;
                load_ch = ccnt_q + 1'b1;
            end else begin
                bcnt_d  = '0;
                ccnt_d  = '0;
                state_d = IDLE;
            end
        end
    end

endmodule

// File: rtl/tdm_tx.sv
// tdm_tx: parametrised TDM/I2S serial transmitter.
// Samples arrive on one AXI-Stream tagged with a slot index and are held one
// per channel until their slot is loaded; each frame serialises NCH slots of
// SLOT_W bits, MSB first, with the I2S one-bit delay after fsync.
// Optional build macro TDM_TX_UNDERRUN_REPEAT_EN: an underrunning slot repeats
// the last sample sent on that channel instead of sending zeros.
// Ports:
//   clk, rst                  : master clock, synchronous active-high reset
//   en                        : transmit enable (gates frame start only)
//   s_axis_tdata/tvalid/tready: sample stream, tid selects the slot
//   s_axis_tid                : destination slot index
//   sclk, fsync               : externally supplied bit clock and frame sync
//   sdo                       : serial data, changes after sclk falling edges
//   underrun                  : one-clk pulse when a slot loads without a sample
//   frame_err                 : one-clk pulse when fsync arrives early
//   tid_err                   : one-clk pulse when a sample with tid >= NCH is taken
module tdm_tx
    import tdm_pkg::*;
#(
    parameter int DW     = 24,
    parameter int SLOT_W = 32,
    parameter int NCH    = 8,
    parameter int TIDW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DW-1:0]   s_axis_tdata,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    input  logic [TIDW-1:0] s_axis_tid,
    input  logic            sclk,
    input  logic            fsync,
    output logic            sdo,
    output logic            underrun,
    output logic            frame_err,
    output logic            tid_err
);

    localparam int CW = bcnt_width(NCH);

    logic              load;
    logic              fall;
    logic              running;
    logic [CW-1:0]     load_ch;
    logic [CW-1:0]     tid_idx;
    logic              tid_ok;
    logic              accept;

    logic [DW-1:0]     hold_q [NCH];
    logic [DW-1:0]     hold_d [NCH];
    logic [NCH-1:0]    vld_q, vld_d;
    logic [SLOT_W-1:0] shreg_q, shreg_d;
    logic              sdo_q, sdo_d;
    logic              underrun_q, underrun_d;
    logic              tid_err_q, tid_err_d;
`ifdef TDM_TX_UNDERRUN_REPEAT_EN
    logic [DW-1:0]     last_q [NCH];
    logic [DW-1:0]     last_d [NCH];
`endif

    // Left-justify a sample inside a slot, padding the tail with zeros.
    function automatic logic [SLOT_W-1:0] slot_word(input logic [DW-1:0] s);
        logic [SLOT_W-1:0] w;
        w = '0;
        w[SLOT_W-1 -: DW] = s;
        return w;
    endfunction

    tdm_slot_timer #(
        .SLOT_W (SLOT_W),
        .NCH    (NCH)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sclk      (sclk),
        .fsync     (fsync),
        .load      (load),
        .load_ch   (load_ch),
        .fall      (fall),
        .running   (running),
        .frame_err (frame_err)
    );

    assign tid_ok  = (32'(s_axis_tid) < 32'(NCH));
    assign tid_idx = CW'(s_axis_tid);
    // Out-of-range ids are always taken (and discarded) so they cannot stall
    // the stream; the vld lookup is only meaningful when tid_ok.
    assign s_axis_tready = ~tid_ok | ~vld_q[tid_idx];
    assign accept        = s_axis_tvalid & s_axis_tready;

    assign sdo      = sdo_q;
    assign underrun = underrun_q;
    assign tid_err  = tid_err_q;

    // Holding store, shift register and output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                hold_q[i] <= '0;
`ifdef TDM_TX_UNDERRUN_REPEAT_EN
                last_q[i] <= '0;
`endif
            end
            vld_q      <= '0;
            shreg_q    <= '0;
            sdo_q      <= 1'b0;
            underrun_q <= 1'b0;
            tid_err_q  <= 1'b0;
        end else begin
            hold_q     <= hold_d;
`ifdef TDM_TX_UNDERRUN_REPEAT_EN
            last_q     <= last_d;
`endif
            vld_q      <= vld_d;
            shreg_q    <= shreg_d;
            sdo_q      <= sdo_d;
            underrun_q <= underrun_d;
            tid_err_q  <= tid_err_d;
        end
    end

    // Slot load is evaluated before the stream write so that a sample for a
    // channel arriving in the very clk its slot loads empty is kept for the
    // next frame rather than being consumed late.
    always_comb begin
        hold_d     = hold_q;
        vld_d      = vld_q;
        shreg_d    = shreg_q;
        sdo_d      = sdo_q;
        underrun_d = 1'b0;
        tid_err_d  = 1'b0;
`ifdef TDM_TX_UNDERRUN_REPEAT_EN
        last_d     = last_q;
`endif

        if (fall) begin
            sdo_d   = shreg_q[SLOT_W-1];
            shreg_d = shreg_q << 1;
        end
        if (!running) begin
            shreg_d = '0;
        end

        if (load) begin
            if (vld_q[load_ch]) begin
                shreg_d        = slot_word(hold_q[load_ch]);
                vld_d[load_ch] = 1'b0;
`ifdef TDM_TX_UNDERRUN_REPEAT_EN
                last_d[load_ch] = hold_q[load_ch];
`endif
            end else begin
                underrun_d = 1'b1;
`ifdef TDM_TX_UNDERRUN_REPEAT_EN
                shreg_d    = slot_word(last_q[load_ch]);
`else
                shreg_d    = '0;
`endif
            end
        end

        if (accept) begin
            if (tid_ok) begin
                hold_d[tid_idx] = s_axis_tdata;
                vld_d[tid_idx]  = 1'b1;
            end else begin
                tid_err_d = 1'b1;
            end
        end
    end

endmodule
